ps2_byte_rx: RTL and testbench
==============================

Name: ps2_byte_rx

Overview:
- PS/2 device-to-host serial receiver. Samples the keyboard's ps2_clock/ps2_data lines and assembles 11-bit frames.
- Emits each valid scan-code byte on ps2_key_data with a one-cycle ps2_key_pressed strobe.
- Sits between the board PS/2 pins and the key-decode logic (speed selection, direction control), which compare ps2_key_data against configured key codes.

Parameters:
- FILTER_LEN, 8, consecutive stable system-clock samples required before the filtered ps2_clock changes level.
- TIMEOUT_CYCLES, 50000, idle cycles allowed between falling edges inside a frame before the frame is aborted.

Ports:
- clock  in  1  system clock.
- reset  in  1  reset.
- ps2_clock  in  1  raw PS/2 clock line, asynchronous.
- ps2_data  in  1  raw PS/2 data line, asynchronous.
- ps2_key_data  out  8  last valid received byte.
- ps2_key_pressed  out  1  one-cycle strobe: ps2_key_data updated this cycle.
- ps2_error  out  1  one-cycle strobe: frame rejected (parity, stop, or timeout).

Behaviour:
- Interface decision: one clock (clock); reset is synchronous and active-high (reset).
- Reset values: ps2_key_data=8'h00, ps2_key_pressed=0, ps2_error=0, filtered clock=1, state=IDLE, bit counter=0, timeout counter=0.
- Input conditioning:
  - Both lines pass through a 2-flop synchronizer.
  - The filtered level takes the synchronized value only after FILTER_LEN consecutive identical samples.
- Sampling: a falling edge is filtered ps2_clock going 1->0. Data is sampled on the cycle that edge is detected.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on an edge with data=0 (start bit), go to DATA and clear the counter. An edge with data=1 is ignored: stay IDLE, no error.
  - DATA: shift data in LSB first. After the 8th bit, go to PARITY.
  - PARITY: capture the parity bit, go to STOP.
  - STOP: on the edge, validate, then return to IDLE.
- Validation:
  - Odd parity: XOR of 8 data bits and the parity bit must be 1.
  - Stop bit must be 1.
  - Pass: on the cycle after the stop-bit edge, ps2_key_data <= byte and ps2_key_pressed=1 for exactly one cycle.
  - Fail: ps2_error=1 for one cycle; ps2_key_data unchanged; ps2_key_pressed stays 0.
- Latency: exactly 1 clock from stop-edge detection to strobe.
- Timeout:
  - In any non-IDLE state, the counter increments each cycle and clears on every falling edge.
  - When it reaches TIMEOUT_CYCLES: ps2_error pulse, partial byte discarded, go to IDLE.
- Strobes: ps2_key_pressed and ps2_error are never asserted in the same cycle.
- Back-to-back frames: a start edge arriving in the cycle after a stop is accepted normally.
- Reset mid-frame: partial frame discarded, no strobe. The next frame is recognised only from a fresh start bit.
- Clock-line glitches shorter than FILTER_LEN cycles produce no edge.

Optional Feature:
- Macro: PS2_BREAK_FILTER_EN.
- Defined:
  - A valid byte 8'hF0 sets break_pending and produces no ps2_key_pressed.
  - The next valid byte clears break_pending, updates ps2_key_data, and also produces no strobe.
  - Result: downstream logic sees make codes only.
  - ps2_error clears break_pending. Reset clears break_pending.
  - 8'hE0 is passed through as a normal byte.
- Undefined: every valid byte, including F0, strobes ps2_key_pressed.

Decomposition:
- Package ps2_pkg holds:
  - FSM state enum (IDLE, DATA, PARITY, STOP).
  - PS2_BREAK_CODE=8'hF0, PS2_EXT_CODE=8'hE0.
  - PS2_DATA_BITS=8.
- Sub-module ps2_line_filter (synchronizer plus FILTER_LEN stability filter, reset value 1), instantiated once per line.

Test Plan:
- Valid frame: start 0, data 0x1D LSB-first, parity 1, stop 1 (edges every 2000 cycles) -> ps2_key_data=0x1D, one ps2_key_pressed pulse, ps2_error=0.
- Bad parity: 0x1D with parity 0 -> one ps2_error pulse, no ps2_key_pressed, ps2_key_data keeps prior 0x1D.
- Break sequence: frames F0 (parity 1) then 1D (parity 1).
  - Macro defined -> zero key strobes, ps2_key_data=0x1D.
  - Macro undefined -> two strobes showing F0 then 1D.
- Timeout recovery: start plus 4 data bits, then idle TIMEOUT_CYCLES+5 -> exactly one ps2_error. A following full 0x1C frame (parity 0) -> ps2_key_data=0x1C, one strobe.
- Reset mid-frame: assert reset for 1 cycle after bit 5 of a 0x1D frame -> no strobe, outputs at reset values. A subsequent 0x1C frame decodes correctly.
- Glitch immunity: 3-cycle low pulse on ps2_clock while IDLE with ps2_data=0 (FILTER_LEN=8) -> state stays IDLE. A following valid 0x1D frame decodes.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types, constants and the frame parity helper.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam int         PS2_DATA_BITS  = 8;
    localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
    localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;

    // PS/2 uses odd parity across the eight data bits plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_byte_rx_if.sv
// Received-byte bus from the PS/2 receiver to the key-decode logic.
interface ps2_byte_rx_if;

    logic [7:0] ps2_key_data;
    logic       ps2_key_pressed;
    logic       ps2_error;

    modport master (output ps2_key_data, output ps2_key_pressed, output ps2_error);
    modport slave  (input  ps2_key_data, input  ps2_key_pressed, input  ps2_error);

endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a stability filter; idles high like the PS/2 bus.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic line_raw,
    output logic line_filt
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             filt_r;
    logic [CNT_W-1:0] cnt_r;

    // Bring the asynchronous pin into the clock domain.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= line_raw;
            sync2_r <= sync1_r;
        end
    end

    // Count consecutive samples that disagree with the filtered level; flip after FILTER_LEN.
    always_ff @(posedge clock) begin
        if (reset) begin
            filt_r <= 1'b1;
            cnt_r  <= '0;
        end else if (sync2_r == filt_r) begin
            cnt_r <= '0;
        end else if (cnt_r == CNT_W'(FILTER_LEN - 1)) begin
            filt_r <= sync2_r;
            cnt_r  <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign line_filt = filt_r;

endmodule

// File: rtl/ps2_byte_rx.sv
// PS/2 device-to-host byte receiver with parity/stop/timeout checking.
// Optional PS2_BREAK_FILTER_EN suppresses strobes for F0 break prefixes and the byte after.
module ps2_byte_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ps2_clock,
    input  logic               ps2_data,
    ps2_byte_rx_if.master      key_if
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic             clk_filt_s;
    logic             data_filt_s;
    logic             clk_prev_r;
    logic             fall_s;
    ps2_state_e       state_r;
    ps2_state_e       next_state_s;
    logic [2:0]       bit_cnt_r;
    logic [7:0]       shift_r;
    logic             parity_r;
    logic [TMO_W-1:0] tmo_cnt_r;
    logic             timeout_s;
    logic             frame_good_s;
    logic             frame_bad_s;
    logic [7:0]       key_data_r;
    logic             pressed_r;
    logic             error_r;
    logic [7:0]       key_data_nxt_s;
    logic             pressed_nxt_s;
    logic             error_nxt_s;
`ifdef PS2_BREAK_FILTER_EN
    logic             break_pending_r;
    logic             break_pending_nxt_s;
`endif

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clock     (clock),
        .reset     (reset),
        .line_raw  (ps2_clock),
        .line_filt (clk_filt_s)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clock     (clock),
        .reset     (reset),
        .line_raw  (ps2_data),
        .line_filt (data_filt_s)
    );

    // Delayed copy of the filtered clock for falling-edge detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_prev_r <= 1'b1;
        end else begin
            clk_prev_r <= clk_filt_s;
        end
    end

    assign fall_s    = clk_prev_r & ~clk_filt_s;
    assign timeout_s = (state_r != IDLE) && !fall_s && (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic plus frame verdict on the stop-bit edge.
    always_comb begin
        next_state_s = state_r;
        frame_good_s = 1'b0;
        frame_bad_s  = 1'b0;
        if (timeout_s) begin
            next_state_s = IDLE;
            frame_bad_s  = 1'b1;
        end else if (fall_s) begin
            case (state_r)
                IDLE: begin
                    if (!data_filt_s) begin
                        next_state_s = DATA;
                    end else begin
                        next_state_s = IDLE;
                    end
                end
                DATA: begin
                    if (bit_cnt_r == 3'(PS2_DATA_BITS - 1)) begin
                        next_state_s = PARITY;
                    end else begin
                        next_state_s = DATA;
                    end
                end
                PARITY: next_state_s = STOP;
                STOP: begin
                    next_state_s = IDLE;
                    if (odd_parity_ok(shift_r, parity_r) && data_filt_s) begin
                        frame_good_s = 1'b1;
                    end else begin
                        frame_bad_s = 1'b1;
                    end
                end
                default: next_state_s = IDLE;
            endcase
        end else begin
            next_state_s = state_r;
        end
    end

    // Shift register, bit counter and parity capture, all advanced on clock falling edges.
    always_ff @(posedge clock) begin
        if (reset) begin
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
            parity_r  <= 1'b0;
        end else if (fall_s) begin
            case (state_r)
                IDLE: begin
                    bit_cnt_r <= 3'd0;
                    shift_r   <= 8'h00;
                end
                DATA: begin
                    shift_r   <= {data_filt_s, shift_r[7:1]};
                    bit_cnt_r <= bit_cnt_r + 3'd1;
                end
                PARITY:  parity_r <= data_filt_s;
                default: parity_r <= parity_r;
            endcase
        end
    end

    // Inter-edge watchdog: only runs while a frame is in progress.
    always_ff @(posedge clock) begin
        if (reset) begin
            tmo_cnt_r <= '0;
        end else if ((state_r == IDLE) || fall_s || timeout_s) begin
            tmo_cnt_r <= '0;
        end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end
    end

    // Decide what the output registers show on the cycle after the verdict.
    always_comb begin
        key_data_nxt_s = key_data_r;
        pressed_nxt_s  = 1'b0;
        error_nxt_s    = 1'b0;
`ifdef PS2_BREAK_FILTER_EN
        break_pending_nxt_s = break_pending_r;
        if (frame_bad_s) begin
            error_nxt_s         = 1'b1;
            break_pending_nxt_s = 1'b0;
        end else if (frame_good_s) begin
            if (break_pending_r) begin
                break_pending_nxt_s = 1'b0;
                key_data_nxt_s      = shift_r;
            end else if (shift_r == PS2_BREAK_CODE) begin
                break_pending_nxt_s = 1'b1;
            end else begin
                key_data_nxt_s = shift_r;
                pressed_nxt_s  = 1'b1;
            end
        end else begin
            break_pending_nxt_s = break_pending_r;
        end
`else
        if (frame_bad_s) begin
            error_nxt_s = 1'b1;
        end else if (frame_good_s) begin
            key_data_nxt_s = shift_r;
            pressed_nxt_s  = 1'b1;
        end else begin
            key_data_nxt_s = key_data_r;
        end
`endif
    end

    // Output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            key_data_r <= 8'h00;
            pressed_r  <= 1'b0;
            error_r    <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
            break_pending_r <= 1'b0;
`endif
        end else begin
            key_data_r <= key_data_nxt_s;
            pressed_r  <= pressed_nxt_s;
            error_r    <= error_nxt_s;
`ifdef PS2_BREAK_FILTER_EN
            break_pending_r <= break_pending_nxt_s;
`endif
        end
    end

    assign key_if.ps2_key_data    = key_data_r;
    assign key_if.ps2_key_pressed = pressed_r;
    assign key_if.ps2_error       = error_r;

endmodule

// File: tb/tb_ps2_byte_rx.sv
// Directed scoreboard bench for ps2_byte_rx; expected strobes are queued as frames are sent.
module tb_ps2_byte_rx;
    import ps2_pkg::*;

    localparam int HALF    = 50;
    localparam int TMO     = 1000;
    localparam int FLT     = 8;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } exp_t;

    logic clock;
    logic reset;
    logic ps2_clock;
    logic ps2_data;
    int   n_cmp;
    int   n_bad;
    exp_t exp_q[$];
    exp_t mon_e;

    ps2_byte_rx_if bus ();

    ps2_byte_rx #(.FILTER_LEN(FLT), .TIMEOUT_CYCLES(TMO)) dut (
        .clock     (clock),
        .reset     (reset),
        .ps2_clock (ps2_clock),
        .ps2_data  (ps2_data),
        .key_if    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push_key(input logic [7:0] d);
        exp_t e;
        e.is_err = 1'b0;
        e.data   = d;
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1;
        e.data   = 8'h00;
        exp_q.push_back(e);
    endtask

    // Drive the first n bits of an LSB-first frame, one falling edge per bit.
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            wait_cycles(HALF);
            ps2_clock = 1'b0;
            wait_cycles(HALF);
            ps2_clock = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    function automatic logic [10:0] frame(input logic [7:0] d, input logic par, input logic stp);
        return {stp, par, d, 1'b0};
    endfunction

    task automatic settle_and_check_empty(input string tag);
        wait_cycles(40);
        @(negedge clock);
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: every strobe must match the oldest expected event.
    always @(negedge clock) begin
        if (!reset && (bus.ps2_key_pressed === 1'b1 || bus.ps2_error === 1'b1)) begin
            check("strobe_exclusive", {31'd0, bus.ps2_key_pressed & bus.ps2_error}, 32'd0);
            check("strobe_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("strobe_kind", {31'd0, bus.ps2_error}, {31'd0, mon_e.is_err});
                if (!mon_e.is_err) begin
                    check("strobe_data", {24'd0, bus.ps2_key_data}, {24'd0, mon_e.data});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        reset     = 1'b1;
        ps2_clock = 1'b1;
        ps2_data  = 1'b1;
        wait_cycles(5);
        @(negedge clock);
        check("reset_data", {24'd0, bus.ps2_key_data}, 32'h00);
        check("reset_pressed", {31'd0, bus.ps2_key_pressed}, 32'd0);
        check("reset_error", {31'd0, bus.ps2_error}, 32'd0);
        reset = 1'b0;
        wait_cycles(20);

        // Valid 0x1D frame.
        push_key(8'h1D);
        send_bits(frame(8'h1D, 1'b1, 1'b1), 11);
        settle_and_check_empty("valid_1d_done");
        check("valid_1d_data", {24'd0, bus.ps2_key_data}, 32'h1D);

        // Bad parity keeps the previous byte.
        push_err();
        send_bits(frame(8'h1D, 1'b0, 1'b1), 11);
        settle_and_check_empty("bad_parity_done");
        check("bad_parity_data", {24'd0, bus.ps2_key_data}, 32'h1D);

        // Bad stop bit.
        push_err();
        send_bits(frame(8'h2A, 1'b0, 1'b0), 11);
        settle_and_check_empty("bad_stop_done");

        // Break sequence F0 then 1D.
`ifndef PS2_BREAK_FILTER_EN
        push_key(8'hF0);
        push_key(8'h1D);
`endif
        send_bits(frame(8'hF0, 1'b1, 1'b1), 11);
        send_bits(frame(8'h1D, 1'b1, 1'b1), 11);
        settle_and_check_empty("break_done");
        check("break_data", {24'd0, bus.ps2_key_data}, 32'h1D);

        // E0 is an ordinary byte either way.
        push_key(8'hE0);
        send_bits(frame(8'hE0, 1'b0, 1'b1), 11);
        settle_and_check_empty("ext_done");

        // Timeout after a partial frame, then recovery.
        push_err();
        send_bits(frame(8'h1D, 1'b1, 1'b1), 5);
        wait_cycles(TMO + 50);
        @(negedge clock);
        check("timeout_done", 32'(exp_q.size()), 32'd0);
        push_key(8'h1C);
        send_bits(frame(8'h1C, 1'b0, 1'b1), 11);
        settle_and_check_empty("after_timeout_done");
        check("after_timeout_data", {24'd0, bus.ps2_key_data}, 32'h1C);

        // Reset mid-frame discards the partial byte.
        send_bits(frame(8'h1D, 1'b1, 1'b1), 6);
        reset = 1'b1;
        wait_cycles(1);
        reset = 1'b0;
        @(negedge clock);
        check("midreset_data", {24'd0, bus.ps2_key_data}, 32'h00);
        check("midreset_pressed", {31'd0, bus.ps2_key_pressed}, 32'd0);
        check("midreset_error", {31'd0, bus.ps2_error}, 32'd0);
        wait_cycles(TMO + 50);
        @(negedge clock);
        check("midreset_quiet", 32'(exp_q.size()), 32'd0);
        push_key(8'h1C);
        send_bits(frame(8'h1C, 1'b0, 1'b1), 11);
        settle_and_check_empty("after_reset_done");
        check("after_reset_data", {24'd0, bus.ps2_key_data}, 32'h1C);

        // Short clock glitch with data low must not look like a start bit.
        ps2_data = 1'b0;
        wait_cycles(20);
        ps2_clock = 1'b0;
        wait_cycles(3);
        ps2_clock = 1'b1;
        wait_cycles(30);
        @(negedge clock);
        check("glitch_state", {30'd0, dut.state_r}, {30'd0, IDLE});
        ps2_data = 1'b1;
        wait_cycles(20);
        push_key(8'h1D);
        send_bits(frame(8'h1D, 1'b1, 1'b1), 11);
        settle_and_check_empty("after_glitch_done");
        check("after_glitch_data", {24'd0, bus.ps2_key_data}, 32'h1D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
